// File: rtl/heap_copier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | heap_copier                                                                |
// | Copies a run of words inside a request/finished medium, one word at a time |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module heap_copier #(
    parameter  int ADDRS      = 256,
    parameter  int BRAM_WIDTH = 64,
    parameter  int PIECES     = 16,
    localparam int WIDTH      = PIECES * BRAM_WIDTH,
    localparam int ADDR_SIZE  = $clog2(ADDRS)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    input  logic [ADDR_SIZE-1:0] src_in,
    input  logic [ADDR_SIZE-1:0] dst_in,
    input  logic [ADDR_SIZE:0]   count_in,
    output logic                 busy_out,
    output logic                 done_out,
    output logic [ADDR_SIZE-1:0] med_addr_out,
    output logic [WIDTH-1:0]     med_data_out,
    input  logic [WIDTH-1:0]     med_data_in,
    output logic                 med_read_enable_out,
    output logic                 med_write_enable_out,
    input  logic                 med_finished_in
);

    localparam int CNT_SIZE = ADDR_SIZE + 1;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_RD_REQ  = 3'd1;
    localparam logic [2:0] c_ST_RD_WAIT = 3'd2;
    localparam logic [2:0] c_ST_WR_REQ  = 3'd3;
    localparam logic [2:0] c_ST_WR_WAIT = 3'd4;
    localparam logic [2:0] c_ST_DONE    = 3'd5;

    logic [2:0]           r_state;
    logic [2:0]           w_state_next;
    logic [ADDR_SIZE-1:0] r_src_ptr;
    logic [ADDR_SIZE-1:0] r_dst_ptr;
    logic [ADDR_SIZE-1:0] r_addr;
    logic [WIDTH-1:0]     r_buf;
    logic [CNT_SIZE-1:0]  r_idx;
    logic [CNT_SIZE-1:0]  r_count;
    logic [CNT_SIZE-1:0]  w_idx_inc;

    // Counter is one bit wider than the address so a full ADDRS-word copy terminates.
    assign w_idx_inc = r_idx + CNT_SIZE'(1);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state   <= c_ST_IDLE;
            r_src_ptr <= '0;
            r_dst_ptr <= '0;
            r_addr    <= '0;
            r_buf     <= '0;
            r_idx     <= '0;
            r_count   <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                c_ST_IDLE: begin
                    if (start_in) begin
                        r_src_ptr <= src_in;
                        r_dst_ptr <= dst_in;
                        r_count   <= count_in;
                        r_idx     <= '0;
                        r_addr    <= src_in;
                    end
                end
                c_ST_RD_WAIT: begin
                    if (med_finished_in) begin
                        r_buf  <= med_data_in;
                        r_addr <= r_dst_ptr;
                    end
                end
                c_ST_WR_WAIT: begin
                    // Pointers wrap naturally through ADDR_SIZE-bit truncation.
                    if (med_finished_in) begin
                        r_idx     <= w_idx_inc;
                        r_src_ptr <= r_src_ptr + ADDR_SIZE'(1);
                        r_dst_ptr <= r_dst_ptr + ADDR_SIZE'(1);
                        r_addr    <= r_src_ptr + ADDR_SIZE'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next         = r_state;
        busy_out             = 1'b0;
        done_out             = 1'b0;
        med_read_enable_out  = 1'b0;
        med_write_enable_out = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start_in) begin
                    w_state_next = (count_in == '0) ? c_ST_DONE : c_ST_RD_REQ;
                end
            end
            c_ST_RD_REQ: begin
                busy_out            = 1'b1;
                med_read_enable_out = 1'b1;
                w_state_next        = c_ST_RD_WAIT;
            end
            c_ST_RD_WAIT: begin
                busy_out = 1'b1;
                if (med_finished_in) begin
                    w_state_next = c_ST_WR_REQ;
                end
            end
            c_ST_WR_REQ: begin
                busy_out             = 1'b1;
                med_write_enable_out = 1'b1;
                w_state_next         = c_ST_WR_WAIT;
            end
            c_ST_WR_WAIT: begin
                busy_out = 1'b1;
                if (med_finished_in) begin
                    w_state_next = (w_idx_inc < r_count) ? c_ST_RD_REQ : c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                done_out     = 1'b1;
                w_state_next = c_ST_IDLE;
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    assign med_addr_out = r_addr;
    assign med_data_out = r_buf;

endmodule
`default_nettype wire

// File: tb/tb_heap_copier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_heap_copier                                                             |
// | Scoreboarded bench with a random-latency medium responder                  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_heap_copier;

    localparam int ADDRS      = 256;
    localparam int BRAM_WIDTH = 16;
    localparam int PIECES     = 4;
    localparam int WIDTH      = PIECES * BRAM_WIDTH;
    localparam int AW         = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [AW-1:0]    src = '0;
    logic [AW-1:0]    dst = '0;
    logic [AW:0]      count = '0;
    logic             busy, done, rd_en, wr_en;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata = '0;
    logic             resp_fin = 1'b0;
    logic             spur_fin = 1'b0;
    logic             fin;

    assign fin = resp_fin | spur_fin;

    heap_copier #(.ADDRS(ADDRS), .BRAM_WIDTH(BRAM_WIDTH), .PIECES(PIECES)) dut (
        .clk_in(clk), .rst_in(rst), .start_in(start), .src_in(src), .dst_in(dst),
        .count_in(count), .busy_out(busy), .done_out(done), .med_addr_out(addr),
        .med_data_out(wdata), .med_data_in(rdata), .med_read_enable_out(rd_en),
        .med_write_enable_out(wr_en), .med_finished_in(fin)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             wr;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } txn_t;

    txn_t             sb[$];
    logic [WIDTH-1:0] mem[ADDRS];
    logic [WIDTH-1:0] ref_mem[ADDRS];
    int tests_run = 0, failed = 0;
    int cyc = 0, fin_cyc = 0, done_cnt = 0;
    int lat_min = 1, lat_max = 3;
    int abort_at = -1, rd_seen = 0;
    bit abort_hit = 0, late_go = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    function automatic logic [WIDTH-1:0] rnd_word();
        return {$urandom(), $urandom()};
    endfunction

    // Medium model: answers each request after a random latency and checks it against the scoreboard.
    initial begin : responder
        txn_t exp;
        int lat;
        bit w, bad;
        logic [AW-1:0] a;
        logic [WIDTH-1:0] d;
        @(posedge clk); #1;
        forever begin
            if (!(rst === 1'b0 && (rd_en === 1'b1 || wr_en === 1'b1))) begin
                @(posedge clk); #1;
                continue;
            end
            tests_run++;
            if (rd_en === 1'b1 && wr_en === 1'b1) begin
                failed++; $display("FAIL both_enables rd=%b wr=%b required one-hot", rd_en, wr_en);
            end
            w = wr_en; a = addr; d = wdata;
            if (!w && abort_at >= 0 && rd_seen == abort_at) begin
                rd_seen++;
                abort_hit = 1;
                wait (late_go);
                late_go = 0;
                resp_fin = 1'b1;
                @(posedge clk); #1;
                resp_fin = 1'b0;
                continue;
            end
            if (!w) rd_seen++;
            tests_run++;
            if (sb.size() == 0) begin
                failed++; $display("FAIL unexpected_request wr=%b addr=%0d required none", w, a);
            end else begin
                exp = sb.pop_front();
                if (exp.wr !== w || exp.addr !== a || (w && exp.data !== d)) begin
                    failed++;
                    $display("FAIL txn got wr=%b addr=%0d data=%h required wr=%b addr=%0d data=%h",
                             w, a, d, exp.wr, exp.addr, exp.data);
                end
            end
            lat = $urandom_range(lat_max, lat_min);
            bad = 0;
            repeat (lat) begin
                @(posedge clk); #1;
                if (addr !== a || wdata !== d || rd_en !== 1'b0 || wr_en !== 1'b0) bad = 1;
            end
            tests_run++;
            if (bad) begin
                failed++;
                $display("FAIL hold addr=%0d data=%h rd=%b wr=%b required addr=%0d data=%h no pulses",
                         addr, wdata, rd_en, wr_en, a, d);
            end
            if (!w) rdata = mem[a];
            else    mem[a] = d;
            resp_fin = 1'b1;
            fin_cyc = cyc;
            @(posedge clk); #1;
            resp_fin = 1'b0;
            rdata = rnd_word();
            if (sb.size() > 0) begin
                tests_run++;
                if (rd_en !== 1'b1 && wr_en !== 1'b1) begin
                    failed++; $display("FAIL next_latency rd=%b wr=%b required a request pulse", rd_en, wr_en);
                end
            end
        end
    end

    task automatic preload(input int a, input logic [WIDTH-1:0] v);
        mem[a] = v;
        ref_mem[a] = v;
    endtask

    task automatic issue_copy(input int s, input int d, input int c);
        int ra, wa;
        for (int k = 0; k < c; k++) begin
            ra = (s + k) % ADDRS;
            wa = (d + k) % ADDRS;
            sb.push_back('{wr: 1'b0, addr: AW'(ra), data: ref_mem[ra]});
            sb.push_back('{wr: 1'b1, addr: AW'(wa), data: ref_mem[ra]});
            ref_mem[wa] = ref_mem[ra];
        end
        start = 1'b1; src = AW'(s); dst = AW'(d); count = (AW+1)'(c);
        @(posedge clk); #1;
        start = 1'b0; src = AW'($urandom); dst = AW'($urandom); count = (AW+1)'($urandom);
        tests_run++;
        if (c == 0) begin
            if (done !== 1'b1 || busy !== 1'b0 || rd_en !== 1'b0 || wr_en !== 1'b0) begin
                failed++; $display("FAIL zero_done done=%b busy=%b rd=%b wr=%b required 1 0 0 0", done, busy, rd_en, wr_en);
            end
        end else if (rd_en !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
            failed++; $display("FAIL first_read rd=%b busy=%b done=%b required 1 1 0", rd_en, busy, done);
        end
    endtask

    task automatic wait_copy(input int c, input int budget, input int dc0);
        bit got = 0;
        if (c > 0) begin
            for (int i = 0; i < budget; i++) begin
                @(posedge clk); #1;
                if (done === 1'b1) begin got = 1; break; end
            end
            tests_run++;
            if (!got) begin
                failed++; $display("FAIL done_timeout waited=%0d cycles required done pulse", budget);
            end else if (cyc != fin_cyc + 1 || busy !== 1'b0) begin
                failed++; $display("FAIL done_timing cyc=%0d busy=%b required cyc=%0d busy=0", cyc, busy, fin_cyc + 1);
            end
        end
        @(posedge clk); #1;
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0 || (done_cnt - dc0) != 1 || sb.size() != 0) begin
            failed++;
            $display("FAIL after_done done=%b busy=%b pulses=%0d left=%0d required 0 0 1 0",
                     done, busy, done_cnt - dc0, sb.size());
        end
    endtask

    task automatic copy(input int s, input int d, input int c, input int budget);
        int dc0 = done_cnt;
        issue_copy(s, d, c);
        wait_copy(c, budget, dc0);
    endtask

    task automatic check_range(input string name, input int d, input int c);
        int bad = 0;
        for (int k = 0; k < c; k++) if (mem[(d + k) % ADDRS] !== ref_mem[(d + k) % ADDRS]) bad++;
        tests_run++;
        if (bad != 0) begin
            failed++; $display("FAIL %s_mem wrong_words=%0d required 0", name, bad);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0 || wr_en !== 1'b0) begin
            failed++; $display("FAIL reset_ctrl busy=%b done=%b rd=%b wr=%b required 0", busy, done, rd_en, wr_en);
        end
        tests_run++;
        if (addr !== '0 || wdata !== '0) begin
            failed++; $display("FAIL reset_data addr=%0d data=%h required 0", addr, wdata);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] va, vb, vc;
        va = rnd_word(); vb = rnd_word(); vc = rnd_word();
        preload(10, va); preload(11, vb); preload(12, vc);
        lat_min = 1; lat_max = 3;
        copy(10, 40, 3, 200);
        tests_run++;
        if (mem[40] !== va || mem[41] !== vb || mem[42] !== vc) begin
            failed++; $display("FAIL basic_words got %h %h %h required %h %h %h", mem[40], mem[41], mem[42], va, vb, vc);
        end
    endtask

    task automatic test_zero_count();
        bit seen_busy = 0;
        copy(5, 6, 0, 10);
        repeat (3) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || rd_en !== 1'b0 || wr_en !== 1'b0) seen_busy = 1;
        end
        tests_run++;
        if (seen_busy) begin
            failed++; $display("FAIL zero_quiet busy/enables seen=1 required 0");
        end
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] v254, v255;
        v254 = rnd_word(); v255 = rnd_word();
        preload(254, v254); preload(255, v255); preload(0, rnd_word()); preload(1, rnd_word());
        copy(254, 0, 4, 300);
        tests_run++;
        if (mem[0] !== v254 || mem[1] !== v255 || mem[2] !== v254 || mem[3] !== v255) begin
            failed++; $display("FAIL wrap_words got %h %h %h %h required %h %h %h %h",
                               mem[0], mem[1], mem[2], mem[3], v254, v255, v254, v255);
        end
    endtask

    task automatic test_protocol();
        int s, d, c;
        bit noisy;
        lat_min = 1; lat_max = 20;
        for (int n = 0; n < 4; n++) begin
            noisy = 0;
            repeat (3) begin
                spur_fin = 1'b1; @(posedge clk); #1;
                spur_fin = 1'b0; @(posedge clk); #1;
                if (busy !== 1'b0 || rd_en !== 1'b0 || wr_en !== 1'b0) noisy = 1;
            end
            tests_run++;
            if (noisy) begin
                failed++; $display("FAIL spurious_idle reaction seen required none");
            end
            s = $urandom_range(255, 0); d = $urandom_range(255, 0); c = $urandom_range(6, 1);
            copy(s, d, c, 400);
            check_range("protocol", d, c);
        end
        lat_min = 1; lat_max = 3;
    endtask

    task automatic test_reset_midop();
        bit bad = 0;
        int dc0;
        lat_min = 1; lat_max = 3;
        rd_seen = 0; abort_hit = 0; late_go = 0; abort_at = 1;
        dc0 = done_cnt;
        issue_copy(60, 80, 5);
        for (int i = 0; i < 200 && !abort_hit; i++) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0 || wr_en !== 1'b0 || addr !== '0 || wdata !== '0) begin
            failed++; $display("FAIL abort_outputs busy=%b done=%b rd=%b wr=%b addr=%0d data=%h required all 0",
                               busy, done, rd_en, wr_en, addr, wdata);
        end
        rst = 1'b0;
        abort_at = -1;
        late_go = 1;
        repeat (5) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0 || wr_en !== 1'b0) bad = 1;
        end
        tests_run++;
        if (bad || done_cnt != dc0 || !abort_hit) begin
            failed++; $display("FAIL abort_quiet activity=%b pulses=%0d hit=%b required 0 0 1", bad, done_cnt - dc0, abort_hit);
        end
        sb.delete();
        for (int k = 0; k < ADDRS; k++) ref_mem[k] = mem[k];
        copy(60, 90, 5, 300);
        check_range("after_abort", 90, 5);
    endtask

    task automatic test_start_busy();
        int dc0 = done_cnt;
        for (int k = 100; k < 105; k++) preload(k, rnd_word());
        issue_copy(100, 150, 5);
        start = 1'b1; src = 8'd7; dst = 8'd9; count = 9'd2;
        @(posedge clk); #1;
        start = 1'b0;
        wait_copy(5, 400, dc0);
        check_range("start_busy", 150, 5);
    endtask

    task automatic test_back_to_back();
        lat_min = 1; lat_max = 1;
        for (int k = 0; k < ADDRS; k++) preload(k, rnd_word());
        copy(0, 0, 256, 5000);
        check_range("full", 0, 256);
        copy(20, 21, 6, 300);
        check_range("overlap", 21, 6);
    endtask

    initial begin
        for (int k = 0; k < ADDRS; k++) begin
            mem[k] = '0;
            ref_mem[k] = '0;
        end
        test_reset();
        test_basic();
        test_zero_count();
        test_wrap();
        test_protocol();
        test_reset_midop();
        test_start_busy();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
`default_nettype wire
